// File: rtl/fsm_pulse_driver.sv
// ---------------------------------------------------------------------------
// fsm_pulse_driver
//
// Transmit-side partner of the 3-state serial pattern detector
// (A=00, B=01, C=10, Out1 high only in C). A command {pulses, width, gap}
// is accepted over a valid/ready handshake. The driver then emits the In1
// bitstream that makes the detector's Out1 produce that pulse train. A
// registered shadow copy of the detector state gives the predicted Out1
// locally.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous reset, active-low (shared with the detector)
//   cmd_valid    command offered
//   cmd_ready    command can be accepted (IDLE only)
//   cmd_pulses   number of Out1 pulses (0 = complete immediately)
//   cmd_width    Out1 high cycles per pulse (0 behaves as 1)
//   cmd_gap      Out1 low cycles between pulses (<2 behaves as 2)
//   tx_bit       serial bit to the detector's In1
//   busy         command in progress
//   done         one-cycle pulse when a command completes
//   model_out1   predicted detector Out1 (shadow == C)
//
// Optional build macro FSM_PULSE_DRIVER_CHECK_EN adds:
//   rx_out1      detector's actual Out1
//   mismatch_err sticky flag, set when rx_out1 differs from model_out1
// ---------------------------------------------------------------------------
module fsm_pulse_driver #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [NUM_W-1:0] cmd_pulses,
    input  logic [CNT_W-1:0] cmd_width,
    input  logic [CNT_W-1:0] cmd_gap,
    output logic             tx_bit,
    output logic             busy,
    output logic             done,
    output logic             model_out1
`ifdef FSM_PULSE_DRIVER_CHECK_EN
    ,
    input  logic             rx_out1,
    output logic             mismatch_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,   // shadow in A; tx=1 on the last cycle moves it to B
        S_PRIME = 2'd2,   // shadow in B; tx=0 moves it to C
        S_HOLD  = 2'd3    // shadow in C; tx=1 on the last cycle returns it to A
    } drv_state_t;

    // Detector encoding. Kept as plain codes so the illegal 11 value can be
    // represented and recovered from.
    localparam logic [1:0] SH_A = 2'b00;
    localparam logic [1:0] SH_B = 2'b01;
    localparam logic [1:0] SH_C = 2'b10;

    drv_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;      // cycles left in ARM or HOLD, 1 = last
    logic [CNT_W-1:0] r_width;    // clamped width W'
    logic [CNT_W-1:0] r_gap;      // clamped gap G'
    logic [NUM_W-1:0] r_pulses;   // pulses remaining, including the current one
    logic             r_done;
    logic [1:0]       r_shadow;

    drv_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_width_nxt;
    logic [CNT_W-1:0] w_gap_nxt;
    logic [NUM_W-1:0] w_pulses_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_width_clamped;
    logic [CNT_W-1:0] w_gap_clamped;

    logic             w_tx_bit;
    logic             w_busy;
    logic             w_cmd_ready;
    logic             w_model_out1;

    assign w_width_clamped = (cmd_width == '0) ? CNT_W'(1) : cmd_width;
    assign w_gap_clamped   = (cmd_gap < CNT_W'(2)) ? CNT_W'(2) : cmd_gap;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_pulses <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_width  <= w_width_nxt;
            r_gap    <= w_gap_nxt;
            r_pulses <= w_pulses_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_width_nxt  = r_width;
        w_gap_nxt    = r_gap;
        w_pulses_nxt = r_pulses;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_width_nxt  = w_width_clamped;
                    w_gap_nxt    = w_gap_clamped;
                    w_pulses_nxt = cmd_pulses;
                    if (cmd_pulses == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        // The shadow already sits in A, so the first pulse
                        // needs only the single arming bit.
                        w_state_nxt = S_ARM;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            S_ARM: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_PRIME;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_PRIME: begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = r_width;
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_pulses_nxt = r_pulses - NUM_W'(1);
                    if (r_pulses == NUM_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // G'-1 cycles in A plus the PRIME cycle in B give a
                        // low time of exactly G'.
                        w_state_nxt = S_ARM;
                        w_cnt_nxt   = r_gap - CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- output decode (registered state only) ----------------
    always_comb begin
        w_tx_bit     = ((r_state == S_ARM) || (r_state == S_HOLD)) && (r_cnt == CNT_W'(1));
        w_busy       = (r_state != S_IDLE);
        w_cmd_ready  = (r_state == S_IDLE);
        w_model_out1 = (r_shadow == SH_C);
    end

    assign tx_bit     = w_tx_bit;
    assign busy       = w_busy;
    assign cmd_ready  = w_cmd_ready;
    assign done       = r_done;
    assign model_out1 = w_model_out1;

    // ---------------- detector shadow ----------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_shadow <= SH_A;
        end else begin
            case (r_shadow)
                SH_A:    r_shadow <= w_tx_bit ? SH_B : SH_A;
                SH_B:    r_shadow <= w_tx_bit ? SH_B : SH_C;
                SH_C:    r_shadow <= w_tx_bit ? SH_A : SH_C;
                default: r_shadow <= SH_A;
            endcase
        end
    end

`ifdef FSM_PULSE_DRIVER_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_mismatch <= 1'b0;
        end else if (rx_out1 != w_model_out1) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch_err = r_mismatch;
`endif

endmodule
